vga_sync_gen: RTL and testbench

Raster timing source for the VGA text/graphics path: divides CLK into a pixel tick and runs horizontal and vertical counters for 640x480 at 60 Hz. It drives registered hsync, vsync, video_on and the pix_x/pix_y scan coordinates that the character/pixel generators consume to select glyphs and colours. It sits between the board clock and the VGA connector, ahead of every RGB generator.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_sync_gen_pixel_tick_div.sv | 42 ++++
 rtl/vga_sync_gen.sv | 118 +++++++++++
 tb/tb_vga_sync_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, total helpers and H/V state encodings.
package vga_timing_pkg;

    localparam int unsigned CNT_W         = 10;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam logic [1:0] H_ST_ACTIVE = 2'd0;
    localparam logic [1:0] H_ST_FRONT  = 2'd1;
    localparam logic [1:0] H_ST_SYNC   = 2'd2;
    localparam logic [1:0] H_ST_BACK   = 2'd3;

    localparam logic [1:0] V_ST_ACTIVE = 2'd0;
    localparam logic [1:0] V_ST_FRONT  = 2'd1;
    localparam logic [1:0] V_ST_SYNC   = 2'd2;
    localparam logic [1:0] V_ST_BACK   = 2'd3;

    function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Divides CLK into a one-cycle pixel tick, high while the divider sits on its last count.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic enable,
    output logic p_tick
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_div_check
        $error("pixel_tick_div: CLK_DIV must be at least 2");
    end

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    always_comb begin
        div_nxt = div_cnt + DW'(1);
        if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
        end
    end

    // p_tick is decoded from the next count so it is high exactly while div_cnt is on its last value
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            p_tick  <= (div_nxt == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick, H/V state machines and counters, registered sync/video outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic             frame_start,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y
);

    localparam int unsigned H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
        $error("vga_sync_gen: raster totals exceed the counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FP_START = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] H_SY_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_BP_START = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FP_START = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] V_SY_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_BP_START = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [1:0]       h_state, h_state_nxt;
    logic [1:0]       v_state, v_state_nxt;
    logic [CNT_W-1:0] x_nxt, y_nxt;
    logic             hsync_nxt, vsync_nxt, video_on_nxt, frame_start_nxt;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .enable (enable),
        .p_tick (p_tick)
    );

    // Next counts and states; all flags decode from these so they line up with pix_x/pix_y
    always_comb begin
        x_nxt       = pix_x;
        y_nxt       = pix_y;
        h_state_nxt = h_state;
        v_state_nxt = v_state;

        if (p_tick) begin
            if (pix_x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (pix_y == V_LAST) ? '0 : pix_y + CNT_W'(1);
                if (y_nxt == '0)             v_state_nxt = V_ST_ACTIVE;
                else if (y_nxt == V_FP_START) v_state_nxt = V_ST_FRONT;
                else if (y_nxt == V_SY_START) v_state_nxt = V_ST_SYNC;
                else if (y_nxt == V_BP_START) v_state_nxt = V_ST_BACK;
            end else begin
                x_nxt = pix_x + CNT_W'(1);
            end

            if (x_nxt == '0)             h_state_nxt = H_ST_ACTIVE;
            else if (x_nxt == H_FP_START) h_state_nxt = H_ST_FRONT;
            else if (x_nxt == H_SY_START) h_state_nxt = H_ST_SYNC;
            else if (x_nxt == H_BP_START) h_state_nxt = H_ST_BACK;
        end

        hsync_nxt       = (h_state_nxt != H_ST_SYNC);
        vsync_nxt       = (v_state_nxt != V_ST_SYNC);
        video_on_nxt    = (h_state_nxt == H_ST_ACTIVE) && (v_state_nxt == V_ST_ACTIVE);
        frame_start_nxt = p_tick && (x_nxt == '0) && (y_nxt == '0);
    end

    // Reset state parks the scan on the last pixel so the first tick lands on (0,0)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            h_state     <= H_ST_BACK;
            v_state     <= V_ST_BACK;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            h_state     <= H_ST_BACK;
            v_state     <= V_ST_BACK;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_x       <= x_nxt;
            pix_y       <= y_nxt;
            h_state     <= h_state_nxt;
            v_state     <= v_state_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance plus a small-raster instance for frame-level behaviour.
module tb_vga_sync_gen;

    localparam int unsigned D_DIV = 4;
    localparam int unsigned S_DIV = 2;
    localparam int unsigned S_HD = 20, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int unsigned S_VD = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int unsigned S_HT = S_HD + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VD + S_VF + S_VS + S_VB;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic enable = 1'b0;

    logic       hsync_d, vsync_d, video_on_d, p_tick_d, frame_start_d;
    logic [9:0] pix_x_d, pix_y_d;
    logic       hsync_s, vsync_s, video_on_s, p_tick_s, frame_start_s;
    logic [9:0] pix_x_s, pix_y_s;

    vga_sync_gen dut_d (
        .CLK(CLK), .RESET(RESET), .enable(enable),
        .hsync(hsync_d), .vsync(vsync_d), .video_on(video_on_d),
        .p_tick(p_tick_d), .frame_start(frame_start_d),
        .pix_x(pix_x_d), .pix_y(pix_y_d)
    );

    vga_sync_gen #(
        .CLK_DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_s (
        .CLK(CLK), .RESET(RESET), .enable(enable),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
        .p_tick(p_tick_s), .frame_start(frame_start_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int unsigned k = 0;   // CLK edges taken since the raster last left its reset state

    wire [24:0] obs_d = {pix_x_d, pix_y_d, hsync_d, vsync_d, video_on_d, p_tick_d, frame_start_d};
    wire [24:0] obs_s = {pix_x_s, pix_y_s, hsync_s, vsync_s, video_on_s, p_tick_s, frame_start_s};

    // Closed-form reference: after k running edges, n = k/div ticks have been applied to the scan
    function automatic logic [24:0] model(input int unsigned kk, input int unsigned div,
                                          input int unsigned hd, input int unsigned hf,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned vd, input int unsigned vf,
                                          input int unsigned vs, input int unsigned vb);
        int unsigned ht, vt, n, l, x, y;
        logic pt, fs, hsy, vsy, vo;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        n  = kk / div;
        pt = ((kk % div) == div - 1);
        if (n == 0) return {10'(ht - 1), 10'(vt - 1), 1'b1, 1'b1, 1'b0, pt, 1'b0};
        l   = (n - 1) % (ht * vt);
        x   = l % ht;
        y   = l / ht;
        hsy = !(x >= hd + hf && x < hd + hf + hs);
        vsy = !(y >= vd + vf && y < vd + vf + vs);
        vo  = (x < hd) && (y < vd);
        fs  = ((kk % div) == 0) && (l == 0);
        return {10'(x), 10'(y), hsy, vsy, vo, pt, fs};
    endfunction

    function automatic logic [24:0] exp_d();
        return model(k, D_DIV, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] exp_s();
        return model(k, S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RESET || !enable) k = 0;
        else k = k + 1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b1; k = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (obs_d !== {10'd799, 10'd524, 5'b11000})
            $display("FAIL reset_state_d: got %h expected %h", obs_d, {10'd799, 10'd524, 5'b11000});
        checks++;
        if (obs_s !== {10'(S_HT - 1), 10'(S_VT - 1), 5'b11000})
            $display("FAIL reset_state_s: got %h expected %h", obs_s, {10'(S_HT - 1), 10'(S_VT - 1), 5'b11000});
        if (obs_d !== {10'd799, 10'd524, 5'b11000}) errors++;
        if (obs_s !== {10'(S_HT - 1), 10'(S_VT - 1), 5'b11000}) errors++;
        RESET = 1'b0;
        for (int i = 1; i <= int'(D_DIV) + 1; i++) begin
            step();
            checks++;
            if (obs_d !== exp_d()) begin
                errors++;
                $display("FAIL first_tick_d edge %0d: got %h expected %h", i, obs_d, exp_d());
            end
            if (i == int'(D_DIV) - 1) begin
                checks++;
                if (p_tick_d !== 1'b1) begin
                    errors++;
                    $display("FAIL first_p_tick: got %b expected 1", p_tick_d);
                end
            end
            if (i == int'(D_DIV)) begin
                checks++;
                if ({pix_x_d, pix_y_d, video_on_d, frame_start_d} !== {20'd0, 2'b11}) begin
                    errors++;
                    $display("FAIL first_pixel: got x=%0d y=%0d vo=%b fs=%b expected 0 0 1 1",
                             pix_x_d, pix_y_d, video_on_d, frame_start_d);
                end
            end
            if (i == int'(D_DIV) + 1) begin
                checks++;
                if (frame_start_d !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_start_width: got %b expected 0", frame_start_d);
                end
            end
        end
    endtask

    task automatic test_cadence();
        int ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (p_tick_d === 1'b1) ticks++;
            checks++;
            if (p_tick_d !== ((k % D_DIV) == D_DIV - 1) || pix_x_d !== exp_d()[24:15]) begin
                errors++;
                $display("FAIL cadence k=%0d: got p_tick=%b x=%0d expected p_tick=%b x=%0d",
                         k, p_tick_d, pix_x_d, ((k % D_DIV) == D_DIV - 1), exp_d()[24:15]);
            end
        end
        checks++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 10", ticks);
        end
    endtask

    task automatic test_hsync_window();
        int hs_fall = -1, hs_rise = -1, vo_fall = -1, vo_rise = -1;
        logic hs_prev, vo_prev;
        hs_prev = hsync_d; vo_prev = video_on_d;
        for (int i = 0; i < 800 * int'(D_DIV) + 8; i++) begin
            step();
            checks++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                errors++;
                $display("FAIL line_run k=%0d: got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (hs_prev && !hsync_d) hs_fall = int'(pix_x_d);
            if (!hs_prev && hsync_d) hs_rise = int'(pix_x_d);
            if (vo_prev && !video_on_d) vo_fall = int'(pix_x_d);
            if (!vo_prev && video_on_d) vo_rise = int'(pix_x_d);
            hs_prev = hsync_d; vo_prev = video_on_d;
        end
        checks++;
        if (hs_fall != 656 || hs_rise != 752) begin
            errors++;
            $display("FAIL hsync_edges: got fall=%0d rise=%0d expected 656 752", hs_fall, hs_rise);
        end
        checks++;
        if (vo_fall != 640 || vo_rise != 0) begin
            errors++;
            $display("FAIL video_on_edges: got fall=%0d rise=%0d expected 640 0", vo_fall, vo_rise);
        end
    endtask

    task automatic test_line_wrap();
        int guard = 0;
        while (!(pix_x_d == 10'd799 && pix_y_d == 10'd9) && guard < 40000) begin
            step();
            guard++;
            checks++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                errors++;
                $display("FAIL long_run k=%0d: got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
        end
        checks++;
        if (guard >= 40000) begin
            errors++;
            $display("FAIL line_wrap_timeout: got x=%0d y=%0d expected 799 9", pix_x_d, pix_y_d);
        end
        guard = 0;
        while (pix_x_d == 10'd799 && guard < 2 * int'(D_DIV)) begin
            step();
            guard++;
        end
        checks++;
        if ({pix_x_d, pix_y_d} !== {10'd0, 10'd10}) begin
            errors++;
            $display("FAIL line_wrap: got x=%0d y=%0d expected 0 10", pix_x_d, pix_y_d);
        end
    endtask

    task automatic test_frame_wrap();
        int guard = 0, fs_cnt = 0, vs_low = 0, vs_min = 1000, vs_max = -1;
        while (!(pix_x_s == 10'(S_HT - 1) && pix_y_s == 10'(S_VT - 1)) && guard < 2000) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL frame_wrap_timeout: got x=%0d y=%0d expected %0d %0d", pix_x_s, pix_y_s, S_HT - 1, S_VT - 1);
        end
        for (int i = 0; i < 2 * int'(S_DIV); i++) begin
            step();
            if (frame_start_s === 1'b1) begin
                fs_cnt++;
                checks++;
                if ({pix_x_s, pix_y_s, video_on_s} !== {20'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL frame_wrap_pos: got x=%0d y=%0d vo=%b expected 0 0 1", pix_x_s, pix_y_s, video_on_s);
                end
            end
        end
        checks++;
        if (fs_cnt != 1) begin
            errors++;
            $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
        end
        for (int i = 0; i < int'(S_HT * S_VT * S_DIV); i++) begin
            step();
            if (vsync_s === 1'b0) begin
                vs_low++;
                if (int'(pix_y_s) < vs_min) vs_min = int'(pix_y_s);
                if (int'(pix_y_s) > vs_max) vs_max = int'(pix_y_s);
            end
        end
        checks++;
        if (vs_min != int'(S_VD + S_VF) || vs_max != int'(S_VD + S_VF + S_VS - 1) || vs_low != int'(S_VS * S_HT * S_DIV)) begin
            errors++;
            $display("FAIL vsync_window: got rows %0d..%0d for %0d clks expected %0d..%0d for %0d clks",
                     vs_min, vs_max, vs_low, S_VD + S_VF, S_VD + S_VF + S_VS - 1, S_VS * S_HT * S_DIV);
        end
    endtask

    task automatic test_enable_drop();
        for (int it = 0; it < 3; it++) begin
            int n = int'($urandom_range(20, 2000));
            int guard = 0;
            repeat (n) step();
            while (pix_x_d != 10'd300 && guard < 4000) begin
                step();
                guard++;
            end
            checks++;
            if (obs_d !== exp_d() || obs_s !== exp_s() || guard >= 4000) begin
                errors++;
                $display("FAIL pre_drop it=%0d: got %h/%h expected %h/%h x=300", it, obs_d, obs_s, exp_d(), exp_s());
            end
            enable = 1'b0;
            repeat (1 + int'($urandom_range(0, 4))) begin
                step();
                checks++;
                if (obs_d !== {10'd799, 10'd524, 5'b11000} || obs_s !== {10'(S_HT - 1), 10'(S_VT - 1), 5'b11000}) begin
                    errors++;
                    $display("FAIL enable_low it=%0d: got %h/%h expected reset values", it, obs_d, obs_s);
                end
            end
            enable = 1'b1;
            for (int i = 1; i <= int'(D_DIV) + 1; i++) begin
                step();
                checks++;
                if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                    errors++;
                    $display("FAIL restart it=%0d edge %0d: got %h/%h expected %h/%h", it, i, obs_d, obs_s, exp_d(), exp_s());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(pix_x_s == 10'd27 && pix_y_s == 10'd9) && guard < 4000) begin
            step();
            guard++;
        end
        checks++;
        if ({hsync_s, vsync_s} !== 2'b00 || guard >= 4000) begin
            errors++;
            $display("FAIL pre_reset: got hs=%b vs=%b x=%0d y=%0d expected 0 0 27 9", hsync_s, vsync_s, pix_x_s, pix_y_s);
        end
        #2 RESET = 1'b1;
        #1 k = 0;
        checks++;
        if (obs_d !== {10'd799, 10'd524, 5'b11000} || obs_s !== {10'(S_HT - 1), 10'(S_VT - 1), 5'b11000}) begin
            errors++;
            $display("FAIL async_reset: got %h/%h expected reset values", obs_d, obs_s);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_hsync_window();
        test_line_wrap();
        test_frame_wrap();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
